framebuf_bank_scheduler: RTL and testbench
==========================================

// Module: framebuf_bank_scheduler
// PURPOSE
//  Double-buffer (ping-pong) scheduler for the 176x144 framebuffer shared by the camera writer and VGA reader.
//  Grants the writer one bank while the VGA controller scans out the other.
//  Swaps banks only on the rising edge of vsync, so a frame is never displayed torn.
//  Supplies bank base addresses to both sides and counts frames dropped when no bank is free.
// PARAMETERS
//  ADDR_WIDTH      16      framebuffer address width
//  BANK_SIZE       25344   words per bank (176*144); bank1 base = BANK_SIZE
//  TIMEOUT_WIDTH   20      width of write-timeout counter
//  FRAME_TIMEOUT   840000  max cycles in WRITING before abort (2 VGA frames of 800x525)
//  DROP_WIDTH      8       width of dropped-frame counter
// PORTS
//  vga_clk_25      in   1           pixel clock (25 MHz); only clock
//  reset           in   1           asynchronous, active-high reset
//  vsync           in   1           VGA vsync, high during sync pulse
//  wr_frame_start  in   1           1-cycle pulse: writer wants to begin a frame
//  wr_frame_done   in   1           1-cycle pulse: writer finished its frame
//  wr_grant        out  1           writer may write to wr_base bank
//  wr_base         out  ADDR_WIDTH  base address of write bank
//  rd_base         out  ADDR_WIDTH  base address of display bank
//  frame_valid     out  1           at least one complete frame has been swapped in
//  swap_pulse      out  1           1-cycle pulse on each bank swap
//  dropped_frames  out  DROP_WIDTH  saturating count of dropped/aborted frames
// BEHAVIOUR
//  - All outputs and state are registered.
//  - Reset values: state=IDLE, wr_bank=0, rd_bank=1, wr_base=0, rd_base=BANK_SIZE, wr_grant=0,
//    frame_valid=0, swap_pulse=0, dropped_frames=0, timeout count=0, vsync_d=1.
//  - vsync_d resets to 1, so vsync already high at reset release is not seen as an edge.
//  - vs_rise = vsync & ~vsync_d, where vsync_d is vsync delayed one cycle.
//  - Invariant: rd_bank == ~wr_bank at all times. base = bank ? BANK_SIZE : 0.
//  - A swap means: wr_bank<=rd_bank, rd_bank<=wr_bank, bases update, swap_pulse=1 for one cycle, frame_valid<=1 (sticky).
//  - IDLE (wr_grant=0):
//      wr_frame_start -> WRITING; wr_grant=1 from the next cycle; timeout count cleared.
//      wr_frame_done ignored.
//  - WRITING (wr_grant=1; timeout count increments each cycle):
//      wr_frame_done & vs_rise -> swap this edge; -> IDLE.
//      wr_frame_done alone -> PENDING.
//      wr_frame_start without done -> abort current frame, drop++, restart: stay in WRITING, count cleared.
//      wr_frame_start and done together -> done takes priority; the start is dropped (drop++).
//      count == FRAME_TIMEOUT-1 with no done -> drop++; -> IDLE.
//  - PENDING (wr_grant=0; write bank holds a finished frame):
//      vs_rise alone -> swap; -> IDLE.
//      vs_rise & wr_frame_start -> swap; -> WRITING, granted on the new write bank.
//      wr_frame_start without vs_rise -> drop++; stay in PENDING.
//      wr_frame_done ignored.
//  - wr_grant deasserts the cycle after leaving WRITING. wr_base is stable whenever wr_grant=1.
//  - dropped_frames saturates at all-ones and never wraps.
//  - rd_base changes only in the swap cycle, which lies inside the vsync pulse (vertical blanking).
//  - Reset asserted mid-frame returns everything to reset values immediately; no partial swap occurs.
// TESTING
//  1. Reset, start@10, done@1000, vsync rise@5000 -> PENDING @1001; swap_pulse 1 cycle @5001;
//     wr_base=BANK_SIZE, rd_base=0, frame_valid=1.
//  2. done and vs_rise in the same cycle -> swap that cycle; state IDLE; no PENDING visit.
//  3. In PENDING, 3 start pulses before vsync -> dropped_frames=3, wr_grant stays 0, banks unchanged.
//  4. Start without done for 840000 cycles -> wr_grant falls, dropped_frames+1, no swap.
//  5. 300 consecutive drops -> dropped_frames holds 255.
//     Check rd_bank==~wr_bank on every cycle of every test.
//  6. Reset pulse while WRITING with vsync high -> reset values; no swap_pulse after release.

Source files
------------

// File: rtl/framebuf_bank_scheduler.sv
// Ping-pong bank scheduler for the camera-writer / VGA-reader framebuffer.
// Banks swap only on a vsync rising edge, so scan-out never shows a torn frame.
module framebuf_bank_scheduler #(
  parameter int ADDR_WIDTH    = 16,
  parameter int BANK_SIZE     = 25344,
  parameter int TIMEOUT_WIDTH = 20,
  parameter int FRAME_TIMEOUT = 840000,
  parameter int DROP_WIDTH    = 8
) (
  input  logic                  vga_clk_25,
  input  logic                  reset,
  input  logic                  vsync,
  input  logic                  wr_frame_start,
  input  logic                  wr_frame_done,
  output logic                  wr_grant,
  output logic [ADDR_WIDTH-1:0] wr_base,
  output logic [ADDR_WIDTH-1:0] rd_base,
  output logic                  frame_valid,
  output logic                  swap_pulse,
  output logic [DROP_WIDTH-1:0] dropped_frames
);

  typedef enum logic [1:0] {IDLE, WRITING, PENDING} state_t;

  localparam logic [TIMEOUT_WIDTH-1:0] TMO_LAST = TIMEOUT_WIDTH'(FRAME_TIMEOUT - 1);

  state_t                  state_q, state_d;
  logic                    wr_bank_q, wr_bank_d;
  logic                    rd_bank_q, rd_bank_d;
  logic [TIMEOUT_WIDTH-1:0] tmo_q, tmo_d;
  logic [DROP_WIDTH-1:0]   drop_q, drop_d;
  logic                    vsync_dly_q, vsync_dly_d;
  logic                    grant_q, grant_d;
  logic                    valid_q, valid_d;
  logic                    swap_q, swap_d;
  logic [ADDR_WIDTH-1:0]   wr_base_q, wr_base_d;
  logic [ADDR_WIDTH-1:0]   rd_base_q, rd_base_d;
  logic                    vs_rise;
  logic                    do_swap;
  logic                    drop_inc;

  function automatic logic [ADDR_WIDTH-1:0] bank_base(input logic bank);
    return bank ? ADDR_WIDTH'(BANK_SIZE) : '0;
  endfunction

  function automatic logic [DROP_WIDTH-1:0] sat_inc(input logic [DROP_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign vs_rise = vsync & ~vsync_dly_q;

  always_comb begin
    state_d     = state_q;
    wr_bank_d   = wr_bank_q;
    rd_bank_d   = rd_bank_q;
    tmo_d       = tmo_q;
    valid_d     = valid_q;
    vsync_dly_d = vsync;
    do_swap     = 1'b0;
    drop_inc    = 1'b0;

    case (state_q)
      IDLE: begin
        if (wr_frame_start) begin
          state_d = WRITING;
          tmo_d   = '0;
        end
      end
      WRITING: begin
        tmo_d = tmo_q + 1'b1;
        if (wr_frame_done) begin
          // A start arriving with done has no bank to go to; it is lost.
          drop_inc = wr_frame_start;
          if (vs_rise) begin
            do_swap = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = PENDING;
          end
        end else if (wr_frame_start) begin
          drop_inc = 1'b1;
          tmo_d    = '0;
        end else if (tmo_q == TMO_LAST) begin
          drop_inc = 1'b1;
          state_d  = IDLE;
        end
      end
      PENDING: begin
        if (vs_rise) begin
          do_swap = 1'b1;
          if (wr_frame_start) begin
            state_d = WRITING;
            tmo_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end else if (wr_frame_start) begin
          drop_inc = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (do_swap) begin
      wr_bank_d = rd_bank_q;
      rd_bank_d = wr_bank_q;
      valid_d   = 1'b1;
    end

    drop_d    = drop_inc ? sat_inc(drop_q) : drop_q;
    swap_d    = do_swap;
    grant_d   = (state_d == WRITING);
    wr_base_d = bank_base(wr_bank_d);
    rd_base_d = bank_base(rd_bank_d);
  end

  always_ff @(posedge vga_clk_25 or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b1;
      tmo_q       <= '0;
      drop_q      <= '0;
      vsync_dly_q <= 1'b1;
      grant_q     <= 1'b0;
      valid_q     <= 1'b0;
      swap_q      <= 1'b0;
      wr_base_q   <= '0;
      rd_base_q   <= ADDR_WIDTH'(BANK_SIZE);
    end else begin
      state_q     <= state_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      tmo_q       <= tmo_d;
      drop_q      <= drop_d;
      vsync_dly_q <= vsync_dly_d;
      grant_q     <= grant_d;
      valid_q     <= valid_d;
      swap_q      <= swap_d;
      wr_base_q   <= wr_base_d;
      rd_base_q   <= rd_base_d;
    end
  end

  assign wr_grant       = grant_q;
  assign wr_base        = wr_base_q;
  assign rd_base        = rd_base_q;
  assign frame_valid    = valid_q;
  assign swap_pulse     = swap_q;
  assign dropped_frames = drop_q;

endmodule

// File: tb/tb_framebuf_bank_scheduler.sv
// Bench for framebuf_bank_scheduler: table vectors and hand sequences feed a
// queue of expected outputs that is popped and compared one cycle later.
module tb_framebuf_bank_scheduler;

  localparam int AW  = 16;
  localparam int B   = 25344;
  localparam int TMO = 2000;
  localparam int DW  = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          vsync;
  logic          wr_frame_start;
  logic          wr_frame_done;
  logic          wr_grant;
  logic [AW-1:0] wr_base;
  logic [AW-1:0] rd_base;
  logic          frame_valid;
  logic          swap_pulse;
  logic [DW-1:0] dropped_frames;

  int checks = 0;
  int errors = 0;

  framebuf_bank_scheduler #(
    .ADDR_WIDTH(AW), .BANK_SIZE(B), .TIMEOUT_WIDTH(20),
    .FRAME_TIMEOUT(TMO), .DROP_WIDTH(DW)
  ) dut (
    .vga_clk_25(clk), .reset(reset), .vsync(vsync),
    .wr_frame_start(wr_frame_start), .wr_frame_done(wr_frame_done),
    .wr_grant(wr_grant), .wr_base(wr_base), .rd_base(rd_base),
    .frame_valid(frame_valid), .swap_pulse(swap_pulse),
    .dropped_frames(dropped_frames)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic grant;
    int   wbase;
    logic swap;
    logic valid;
    int   drops;
  } exp_t;

  typedef struct {
    logic vs, st, dn;
    logic grant;
    logic wb1;
    logic swap;
    logic valid;
    int   drops;
  } vec_t;

  exp_t exp_q[$];

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
    end
  endtask

  task automatic compare_outputs(input exp_t e);
    chk("wr_grant", int'(wr_grant), int'(e.grant));
    chk("wr_base", int'(wr_base), e.wbase);
    chk("rd_base", int'(rd_base), (e.wbase == 0) ? B : 0);
    chk("swap_pulse", int'(swap_pulse), int'(e.swap));
    chk("frame_valid", int'(frame_valid), int'(e.valid));
    chk("dropped_frames", int'(dropped_frames), e.drops);
  endtask

  // Drive one cycle of inputs, queue what the outputs must be after the edge.
  task automatic vec(input logic vs, input logic st, input logic dn,
                     input logic eg, input int ewb, input logic esw,
                     input logic ev, input int ed);
    exp_t e;
    exp_t got_e;
    e.grant = eg; e.wbase = ewb; e.swap = esw; e.valid = ev; e.drops = ed;
    exp_q.push_back(e);
    vsync = vs; wr_frame_start = st; wr_frame_done = dn;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard: got empty queue expected 1 entry");
    end else begin
      got_e = exp_q.pop_front();
      compare_outputs(got_e);
    end
  endtask

  task automatic check_reset_values(input string tag);
    exp_t e;
    e.grant = 1'b0; e.wbase = 0; e.swap = 1'b0; e.valid = 1'b0; e.drops = 0;
    $display("reset check: %s", tag);
    compare_outputs(e);
  endtask

  // Bank invariant and write-base stability, every cycle outside reset.
  logic          prev_grant = 1'b0;
  logic [AW-1:0] prev_wbase = '0;
  always @(negedge clk) begin
    if (!reset) begin
      chk("bank_invariant", int'(rd_base), (wr_base == AW'(B)) ? 0 : B);
      if (prev_grant && wr_grant)
        chk("wr_base_stable", int'(wr_base), int'(prev_wbase));
    end
    prev_grant <= wr_grant & ~reset;
    prev_wbase <= wr_base;
  end

  vec_t tbl[20];

  initial begin
    tbl = '{
      // done and vsync rise together: swap immediately, no pending stage
      '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 0},
      '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 0},
      '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 0},
      '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 0},
      '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0},
      '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0},
      '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0},
      // pending: three starts are dropped, done ignored, then vsync swaps
      '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0},
      '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0},
      '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1},
      '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2},
      '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3},
      '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3},
      '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 3},
      // restart while writing, start+done priority, swap straight into writing
      '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 3},
      '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4},
      '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 5},
      '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5},
      '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5},
      '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 5}
    };

    reset = 1'b1; vsync = 1'b0; wr_frame_start = 1'b0; wr_frame_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("initial");
    reset = 1'b0;

    // Start at cycle 10, done at 1000, vsync rise at 5000.
    for (int c = 1; c <= 5000; c++)
      vec(c >= 5000, c == 10, c == 1000,
          (c >= 10) && (c < 1000), (c >= 5000) ? B : 0,
          c == 5000, c >= 5000, 0);
    vec(1'b1, 1'b0, 1'b0, 1'b0, B, 1'b0, 1'b1, 0);

    for (int i = 0; i < 20; i++)
      vec(tbl[i].vs, tbl[i].st, tbl[i].dn, tbl[i].grant,
          tbl[i].wb1 ? B : 0, tbl[i].swap, tbl[i].valid, tbl[i].drops);

    // Write timeout: grant falls after TMO cycles, one drop, no swap.
    vec(1'b0, 1'b1, 1'b0, 1'b1, B, 1'b0, 1'b1, 5);
    for (int k = 1; k <= TMO + 2; k++)
      vec(1'b0, 1'b0, 1'b0, k < TMO, B, 1'b0, 1'b1, (k >= TMO) ? 6 : 5);

    // Drop counter saturation.
    vec(1'b0, 1'b1, 1'b0, 1'b1, B, 1'b0, 1'b1, 6);
    vec(1'b0, 1'b0, 1'b1, 1'b0, B, 1'b0, 1'b1, 6);
    for (int i = 1; i <= 300; i++)
      vec(1'b0, 1'b1, 1'b0, 1'b0, B, 1'b0, 1'b1, (6 + i > 255) ? 255 : 6 + i);
    vec(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b1, 255);

    // Reset while writing with vsync high.
    vec(1'b0, 1'b1, 1'b0, 1'b1, 0, 1'b0, 1'b1, 255);
    vec(1'b1, 1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b1, 255);
    reset = 1'b1;
    #1;
    check_reset_values("async mid-frame");
    @(posedge clk);
    #1;
    reset = 1'b0;
    vec(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 0);
    vec(1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0, 0);
    vec(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 0);
    vec(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 0);

    chk("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
